gbe_tx_framer: RTL

UDP/IPv4 frame transmitter for the GbE datapath. It sits between a single-buffered payload store and the Ethernet MAC transmit client interface, in the `mac_clk` domain. On request, it prepends the 14-byte Ethernet, 20-byte IPv4 and 8-byte UDP headers, including the IPv4 header checksum, streams the payload, pads to minimum frame size, and returns the buffer through a four-phase handshake.

---
 rtl/gbe_tx_framer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gbe_tx_framer.sv
// UDP/IPv4 frame transmitter: prepends Ethernet, IPv4 and UDP headers to a
// single-buffered payload, pads to minimum frame size and streams to the MAC.
module gbe_tx_framer #(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic        local_enable,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  input  logic [47:0] dest_mac,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic        pkt_ready,
  input  logic [10:0] pkt_size,
  output logic        pkt_ack,
  output logic        pkt_err,
  output logic [10:0] pld_addr,
  input  logic [7:0]  pld_data,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack
);

  localparam int unsigned IDX_W     = 11;
  localparam int unsigned HDR_LEN   = 42;
  localparam int unsigned HDR_W     = HDR_LEN * 8;
  localparam int unsigned MIN_FRAME = 60;
  localparam int unsigned PREFETCH  = 40;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_WAIT_ACK, S_HDR, S_DATA, S_PAD, S_DONE
  } state_t;

  state_t            state;
  logic [47:0]       lat_local_mac, lat_dest_mac;
  logic [31:0]       lat_local_ip, lat_dest_ip;
  logic [15:0]       lat_local_port, lat_dest_port;
  logic [IDX_W-1:0]  lat_size;
  logic [15:0]       ip_id;
  logic [15:0]       csum;
  logic [19:0]       csum_acc;
  logic [1:0]        calc_cnt;
  logic [IDX_W-1:0]  idx;

  logic [15:0]       size16, ip_len, udp_len;
  logic [19:0]       csum_sum;
  logic [HDR_W-1:0]  hdr_vec, hdr_shift;
  logic [7:0]        hdr_byte;
  logic [IDX_W-1:0]  next_idx, last_idx, pld_stop, pld_end;

  assign size16  = 16'(lat_size);
  assign ip_len  = size16 + 16'd28;
  assign udp_len = size16 + 16'd8;

  // Raw one's-complement sum of the IPv4 header words, checksum word as zero
  assign csum_sum = 20'h04500 + 20'(ip_len) + 20'(ip_id) + 20'h04000 + 20'({TTL, 8'h11})
                  + 20'(lat_local_ip[31:16]) + 20'(lat_local_ip[15:0])
                  + 20'(lat_dest_ip[31:16]) + 20'(lat_dest_ip[15:0]);

  assign hdr_vec = {lat_dest_mac, lat_local_mac, 16'h0800, 16'h4500, ip_len, ip_id,
                    16'h4000, TTL, 8'h11, csum, lat_local_ip, lat_dest_ip,
                    lat_local_port, lat_dest_port, udp_len, 16'h0000};

  assign next_idx  = idx + IDX_W'(1);
  assign hdr_shift = hdr_vec << {next_idx, 3'b000};
  assign hdr_byte  = hdr_shift[HDR_W-1 -: 8];
  assign pld_stop  = lat_size + IDX_W'(HDR_LEN);
  assign pld_end   = lat_size + IDX_W'(PREFETCH);
  assign last_idx  = (lat_size < IDX_W'(MIN_FRAME - HDR_LEN)) ? IDX_W'(MIN_FRAME - 1)
                                                              : lat_size + IDX_W'(HDR_LEN - 1);

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state          <= S_IDLE;
      lat_local_mac  <= '0;
      lat_dest_mac   <= '0;
      lat_local_ip   <= '0;
      lat_dest_ip    <= '0;
      lat_local_port <= '0;
      lat_dest_port  <= '0;
      lat_size       <= '0;
      ip_id          <= '0;
      csum           <= '0;
      csum_acc       <= '0;
      calc_cnt       <= '0;
      idx            <= '0;
      pkt_ack        <= 1'b0;
      pkt_err        <= 1'b0;
      pld_addr       <= '0;
      mac_tx_data    <= '0;
      mac_tx_dvld    <= 1'b0;
    end else begin
      pkt_err <= 1'b0;
      case (state)
        S_IDLE: begin
          pld_addr <= '0;
          if (pkt_ready && local_enable) begin
            lat_local_mac  <= local_mac;
            lat_dest_mac   <= dest_mac;
            lat_local_ip   <= local_ip;
            lat_dest_ip    <= dest_ip;
            lat_local_port <= local_port;
            lat_dest_port  <= dest_port;
            lat_size       <= pkt_size;
            if (pkt_size == '0 || 32'(pkt_size) > MAX_PAYLOAD) begin
              pkt_err <= 1'b1;
              pkt_ack <= 1'b1;
              state   <= S_DONE;
            end else begin
              calc_cnt <= '0;
              state    <= S_CALC;
            end
          end
        end

        // Sum, first fold, then second fold with inversion
        S_CALC: begin
          calc_cnt <= calc_cnt + 2'd1;
          case (calc_cnt)
            2'd0:    csum_acc <= csum_sum;
            2'd1:    csum_acc <= 20'(csum_acc[15:0]) + 20'(csum_acc[19:16]);
            default: begin
              csum        <= ~(csum_acc[15:0] + 16'(csum_acc[19:16]));
              mac_tx_dvld <= 1'b1;
              mac_tx_data <= lat_dest_mac[47:40];
              idx         <= '0;
              state       <= S_WAIT_ACK;
            end
          endcase
        end

        S_WAIT_ACK, S_HDR, S_DATA, S_PAD: begin
          if (state != S_WAIT_ACK || mac_tx_ack) begin
            if (idx == last_idx) begin
              mac_tx_dvld <= 1'b0;
              mac_tx_data <= '0;
              pkt_ack     <= 1'b1;
              ip_id       <= ip_id + 16'd1;
              state       <= S_DONE;
            end else begin
              idx <= next_idx;
              if (next_idx < IDX_W'(HDR_LEN)) begin
                mac_tx_data <= hdr_byte;
                state       <= S_HDR;
              end else if (next_idx < pld_stop) begin
                mac_tx_data <= pld_data;
                state       <= S_DATA;
              end else begin
                mac_tx_data <= 8'h00;
                state       <= S_PAD;
              end
              // Read address leads the output by two so registered pld_data lines up
              if (next_idx >= IDX_W'(PREFETCH) && next_idx < pld_end)
                pld_addr <= next_idx - IDX_W'(PREFETCH);
            end
          end
        end

        S_DONE: begin
          if (!pkt_ready) begin
            pkt_ack <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
